fifo_rd_streamer: RTL and testbench

- Read-side client for fifo_controller: watches the controller's empty flag, issues i_rd pulses and captures words from the 1-cycle-latency synchronous RAM read port.
- Presents the captured words on a valid/ready stream through a 2-entry output buffer.
- Sits between fifo_controller/RAM and any downstream consumer. Sustains one word per cycle when the FIFO is non-empty and the consumer is ready.

---
 rtl/fifo_rd_streamer.sv | 129 ++++++++++++
 tb/tb_fifo_rd_streamer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_streamer.sv
// Read-side streamer for fifo_controller: issues reads and buffers 1-cycle-latency RAM data into a 2-entry valid/ready stream.
// Define FIFO_RD_STATS_EN to add saturating delivered-word and stall-cycle counters.
module fifo_rd_streamer #(
  parameter int DW = 8,
  parameter int SW = 16
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_empty,
  output logic          o_rd,
  input  logic [DW-1:0] i_rdata,
  input  logic          i_flush,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [SW-1:0] o_rd_cnt,
  output logic [SW-1:0] o_stall_cnt
`endif
);

  if (SW < 1) begin : g_sw_check
    $error("fifo_rd_streamer: SW must be at least 1");
  end

  logic [1:0]    cnt_q, cnt_d;
  logic          inflight_q, inflight_d;
  logic          head_q, head_d;
  logic          tail_q, tail_d;
  logic [DW-1:0] buf_q [2];
  logic [DW-1:0] buf_d [2];
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  logic          pop;
  logic          capture;
  logic [2:0]    credit;
  logic          rd;

  always_comb begin
    pop     = valid_q && i_ready;
    capture = inflight_q && !i_flush;
    credit  = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    // Gating with i_rstn makes o_rd drop the instant reset asserts.
    rd      = i_rstn && !i_empty && !i_flush && (credit < 3'd2);

    cnt_d      = cnt_q;
    inflight_d = rd;
    head_d     = head_q;
    tail_d     = tail_q;
    buf_d      = buf_q;

    if (capture) begin
      buf_d[tail_q] = i_rdata;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    cnt_d = cnt_q + {1'b0, capture} - {1'b0, pop};

    if (i_flush) begin
      cnt_d  = 2'd0;
      head_d = 1'b0;
      tail_d = 1'b0;
    end

    // Output flops mirror the post-update buffer head so o_valid/o_data are registered.
    valid_d = (cnt_d != 2'd0);
    data_d  = buf_d[head_d];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  assign o_rd    = rd;
  assign o_valid = valid_q;
  assign o_data  = data_q;

`ifdef FIFO_RD_STATS_EN
  logic [SW-1:0] rd_cnt_q, rd_cnt_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;

  // Both counters saturate and survive flush; only reset clears them.
  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop && (rd_cnt_q != {SW{1'b1}})) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    if (valid_q && !i_ready && (stall_cnt_q != {SW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_rd_cnt    = rd_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench for fifo_rd_streamer: a RAM model pushes each returned word as expected, a monitor checks deliveries.
module tb_fifo_rd_streamer;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_empty;
  logic       o_rd;
  logic [7:0] i_rdata = 8'hEE;
  logic       i_flush;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_ready;
`ifdef FIFO_RD_STATS_EN
  logic [3:0] o_rd_cnt;
  logic [3:0] o_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] ram_q [$];
  logic [7:0] exp_q [$];
  logic       rd_seen = 1'b0;

  fifo_rd_streamer #(.DW(8), .SW(4)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_empty     (i_empty),
    .o_rd        (o_rd),
    .i_rdata     (i_rdata),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .i_ready     (i_ready)
`ifdef FIFO_RD_STATS_EN
    ,
    .o_rd_cnt    (o_rd_cnt),
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  // RAM model: a read seen before an edge returns the next word just after it.
  always @(negedge i_clk) rd_seen = o_rd;

  always @(posedge i_clk) begin
    #1;
    if (rd_seen) begin
      logic [7:0] w;
      w = (ram_q.size() != 0) ? ram_q.pop_front() : 8'hEE;
      i_rdata = w;
      exp_q.push_back(w);
    end else begin
      i_rdata = 8'hEE;
    end
  end

  // Monitor: every accepted word must match the oldest outstanding RAM word.
  always @(negedge i_clk) begin
    if (i_rstn && !i_flush && o_valid && i_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_extra: got %h, expected no word", o_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_data !== e) begin
          bad++;
          $display("[TB] FAIL sb_data: got %h, expected %h", o_data, e);
        end
      end
    end
    if (i_flush) exp_q.delete();
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic empty, input logic ready, input logic flush);
    i_empty = empty;
    i_ready = ready;
    i_flush = flush;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkCycle(input string tag, input logic erd, input logic evalid, input logic [7:0] edata);
    checkOutput({tag, "_rd"}, o_rd, erd);
    checkOutput({tag, "_valid"}, o_valid, evalid);
    if (evalid) checkOutput({tag, "_data"}, o_data, edata);
  endtask

  initial begin
    logic [7:0] t1 [3];
    logic [7:0] t2 [4];
    t1 = '{8'h11, 8'h22, 8'h33};
    t2 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

    i_rstn = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge i_clk);
    #2;
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_data", o_data, 0);
    checkOutput("rst_rd", o_rd, 0);

    // Basic full-rate stream straight out of reset.
    foreach (t1[k]) ram_q.push_back(t1[k]);
    for (int c = 0; c <= 5; c++) begin
      step();
      if (c == 0) i_rstn = 1'b1;
      applyStimulus(c >= 3, 1'b1, 1'b0);
      #1;
      checkCycle("basic", c <= 2, (c >= 2) && (c <= 4), (c >= 2 && c <= 4) ? t1[c-2] : 8'h00);
    end

    // Backpressure: fill both entries, hold, then drain.
    foreach (t2[k]) ram_q.push_back(t2[k]);
    for (int c = 0; c <= 11; c++) begin
      step();
      applyStimulus(c >= 9, c >= 7, 1'b0);
      #1;
      checkCycle("bp", (c <= 1) || (c == 7) || (c == 8), (c >= 2) && (c <= 10),
                 (c <= 7) ? t2[0] : t2[(c >= 8 && c <= 10) ? c - 7 : 0]);
    end

    // Empty held, then released: first valid two cycles after the first read.
    ram_q.push_back(8'hB1);
    ram_q.push_back(8'hB2);
    for (int c = 0; c <= 8; c++) begin
      step();
      applyStimulus(!(c == 5 || c == 6), 1'b0, 1'b0);
      #1;
      checkCycle("empty", (c == 5) || (c == 6), c >= 7, 8'hB1);
    end

    // Flush with a full buffer and nothing in flight.
    step();
    applyStimulus(1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("flush2_rd", o_rd, 0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("flush2_valid", o_valid, 0);

    // Flush with a read in flight: 0x44 must be discarded, 0x55 comes first after.
    ram_q.push_back(8'h40);
    ram_q.push_back(8'h44);
    ram_q.push_back(8'h55);
    ram_q.push_back(8'h66);
    for (int c = 0; c <= 7; c++) begin
      step();
      applyStimulus(c >= 5, 1'b1, c == 2);
      #1;
      checkCycle("flushf", (c <= 1) || (c == 3) || (c == 4), (c == 2) || (c == 5) || (c == 6),
                 (c == 2) ? 8'h40 : ((c == 5) ? 8'h55 : 8'h66));
    end

    // Asynchronous reset mid-cycle, then restart from the next RAM word.
    ram_q.push_back(8'hD1);
    ram_q.push_back(8'hD2);
    ram_q.push_back(8'hD3);
    ram_q.push_back(8'hD4);
    for (int c = 0; c <= 7; c++) begin
      step();
      if (c == 3) i_rstn = 1'b1;
      applyStimulus(c >= 5, 1'b1, 1'b0);
      #1;
      checkCycle("arst", c <= 4, (c == 2) || (c == 5) || (c == 6),
                 (c == 2) ? 8'hD1 : ((c == 5) ? 8'hD3 : 8'hD4));
      if (c == 2) begin
        #1;
        i_rstn = 1'b0;
        #1;
        checkOutput("arst_valid_drop", o_valid, 0);
        checkOutput("arst_rd_drop", o_rd, 0);
        exp_q.delete();
      end
    end

    // Sustained full rate for 20 words.
    for (int k = 0; k < 20; k++) ram_q.push_back(8'h60 + 8'(k));
    for (int c = 0; c <= 22; c++) begin
      step();
      applyStimulus(c >= 20, 1'b1, 1'b0);
      #1;
      checkCycle("rate", c <= 19, (c >= 2) && (c <= 21), 8'h60 + 8'(c - 2));
    end
`ifdef FIFO_RD_STATS_EN
    checkOutput("stats_rd_sat", o_rd_cnt, 15);
`endif

    // Exactly three stall cycles on a single word.
    ram_q.push_back(8'h77);
    for (int c = 0; c <= 6; c++) begin
      step();
      applyStimulus(c != 0, c >= 5, 1'b0);
      #1;
      checkCycle("stall", c == 0, (c >= 2) && (c <= 5), 8'h77);
    end
`ifdef FIFO_RD_STATS_EN
    checkOutput("stats_stall", o_stall_cnt, 3);
    checkOutput("stats_rd_hold", o_rd_cnt, 15);
`endif

    step();
    checkOutput("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
